// File: rtl/roll_unroll_seq.sv
// ============================================================================
// Module   : roll_unroll_seq
// Brief    : Sequential nibble un-roll; undoes the roll stage's prefix sum,
//            decoding one nibble per clock behind valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module roll_unroll_seq #(
  parameter int NIBBLES = 8,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   busy,
  output logic [CNT_W-1:0]       done_cnt
);

  localparam int W      = 4 * NIBBLES;
  localparam int LANE_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [W-1:0]        r_word;
  logic [W-1:0]        r_acc;
  logic [W-1:0]        w_acc_next;
  logic [3:0]          r_prev;
  logic [3:0]          w_cur;
  logic [3:0]          w_diff;
  logic [LANE_W-1:0]   r_lane;
  logic                w_last;

  assign w_last = (r_lane == LANE_W'(NIBBLES - 1));
  assign w_diff = w_cur - r_prev;

  // Select the current lane and merge its difference into the accumulator.
  always_comb begin
    w_cur      = 4'd0;
    w_acc_next = r_acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_lane == LANE_W'(i)) begin
        w_cur = r_word[4*i +: 4];
      end
    end
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_lane == LANE_W'(i)) begin
        w_acc_next[4*i +: 4] = w_diff;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // out_data is only updated on entry to DONE so consumers never see partials.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word   <= '0;
      r_acc    <= '0;
      r_prev   <= 4'd0;
      r_lane   <= '0;
      out_data <= '0;
      done_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_word <= in_data;
            r_acc  <= '0;
            r_prev <= 4'd0;
            r_lane <= '0;
          end
        end
        ST_CALC: begin
          r_acc  <= w_acc_next;
          r_prev <= w_cur;
          r_lane <= r_lane + LANE_W'(1);
          if (w_last) begin
            out_data <= w_acc_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_lane <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_roll_unroll_seq.sv
// ============================================================================
// Module   : tb_roll_unroll_seq
// Brief    : Directed self-checking bench for roll_unroll_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_roll_unroll_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [15:0] done_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic        busy2;
  logic [1:0]  done_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  roll_unroll_seq #(.NIBBLES(8), .CNT_W(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  roll_unroll_seq #(.NIBBLES(8), .CNT_W(2)) u_dut_small (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .busy      (busy2),
    .done_cnt  (done_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] roll(input logic [31:0] a);
    logic [3:0]  s;
    logic [31:0] r;
    s = 4'd0;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + a[4*i +: 4];
      r[4*i +: 4] = s;
    end
    return r;
  endfunction

  // Send one word from IDLE, wait for the result and complete the handshake.
  task automatic xfer(input string tag, input logic [31:0] d, input logic [31:0] exp);
    int n;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
    tick();
  endtask

  initial begin
    int n;
    int gap;
    logic [31:0] a;
    logic        got_it;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done_cnt", done_cnt, 0);
    tick();
    reset = 1'b0;

    // Basic decode with exact latency.
    in_valid  = 1'b1;
    in_data   = 32'h87654321;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("calc_busy", busy, 1);
    check("calc_in_ready", in_ready, 0);
    for (int i = 1; i < 8; i++) tick();
    check("lat7_out_valid", out_valid, 0);
    tick();
    check("lat8_out_valid", out_valid, 1);
    check("basic_data", out_data, 32'h11111111);
    tick();
    check("basic_cnt", done_cnt, 1);
    check("basic_idle", in_ready, 1);

    // Wrap-around lanes.
    do_reset();
    xfer("wrap", 32'h89ABCDEF, 32'hFFFFFFFF);
    xfer("zero", 32'h00000000, 32'h00000000);
    check("wrap_cnt", done_cnt, 2);

    // Backpressure in DONE with a second word waiting.
    in_valid  = 1'b1;
    in_data   = 32'h87654321;
    out_ready = 1'b0;
    tick();
    in_data = 32'h89ABCDEF;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_reach", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'h11111111);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    check("bp_cnt", done_cnt, 3);
    tick();
    check("bp_second_accept", busy, 1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_second_data", out_data, 32'hFFFFFFFF);
    tick();
    check("bp_second_cnt", done_cnt, 4);

    // Asynchronous reset mid-CALC.
    in_valid = 1'b1;
    in_data  = 32'h87654321;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_cnt", done_cnt, 0);
    check("arst_data", out_data, 0);
    #1;
    reset = 1'b0;
    tick();
    xfer("arst_fresh", 32'h89ABCDEF, 32'hFFFFFFFF);
    check("arst_fresh_cnt", done_cnt, 1);

    // Small counter wraps after four completions.
    do_reset();
    xfer("cw1", 32'h87654321, 32'h11111111);
    check("cw_cnt1", done_cnt2, 2'd1);
    xfer("cw2", 32'h89ABCDEF, 32'hFFFFFFFF);
    check("cw_cnt2", done_cnt2, 2'd2);
    xfer("cw3", 32'h00000000, 32'h00000000);
    check("cw_cnt3", done_cnt2, 2'd3);
    xfer("cw4", 32'h87654321, 32'h11111111);
    check("cw_cnt4", done_cnt2, 2'd0);
    xfer("cw5", 32'h89ABCDEF, 32'hFFFFFFFF);
    check("cw_cnt5", done_cnt2, 2'd1);
    check("cw_small_data", out_data2, 32'hFFFFFFFF);

    // Round trip with random gaps and backpressure.
    do_reset();
    for (int w = 0; w < 200; w++) begin
      a   = $urandom;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        out_ready = $urandom_range(0, 1) == 1;
        tick();
      end
      in_valid = 1'b1;
      in_data  = roll(a);
      n = 0;
      while (!in_ready && n < 40) begin
        tick();
        n++;
      end
      tick();
      in_valid = 1'b0;
      got_it = 1'b0;
      n = 0;
      while (!got_it && n < 100) begin
        out_ready = $urandom_range(0, 1) == 1;
        if (out_valid && out_ready) begin
          check("rt_data", out_data, a);
          got_it = 1'b1;
        end
        tick();
        n++;
      end
      if (!got_it) check("rt_timeout", got_it, 1);
    end
    check("rt_cnt", done_cnt, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
